// File: rtl/ISO14443A_pkg.sv
// Shared ISO/IEC 14443-3 type A definitions for the PICC->PCD transmit path.
// Latency/backpressure: n/a (types and constants only).
// Holds the frame sequencer state encoding and the CRC_A preset.
package ISO14443A_pkg;

    localparam logic [15:0] CRC_A_PRESET = 16'h6363;

    typedef enum logic [2:0] {
        IDLE,
        SOC,
        DATA,
        PARITY,
        CRC_LO,
        CRC_HI
    } tx_state_t;

endpackage

// File: rtl/crc_a_byte.sv
// Byte-wise CRC_A (reflected x^16+x^12+x^5+1) next-state function.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module crc_a_byte (
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    logic [7:0] mix;
    logic [7:0] fold;

    always_comb begin
        mix      = data ^ crc[7:0];
        fold     = mix ^ {mix[3:0], 4'b0000};
        crc_next = {8'h00, crc[15:8]}
                 ^ {fold, 8'h00}
                 ^ {5'b00000, fold, 3'b000}
                 ^ {12'h000, fold[7:4]};
    end

endmodule

// File: rtl/tx_frame_sequencer.sv
// Serialises 14443-A standard frames: start bit, LSb-first data with odd parity, optional CRC_A.
// Latency: first bit presented the cycle after the first-byte accept; one bit per out_ready slot.
// Backpressure: outputs hold while out_ready is low; next byte only taken during a parity slot.
module tx_frame_sequencer
    import ISO14443A_pkg::*;
#(
    parameter logic [15:0] CRC_INIT = CRC_A_PRESET
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic [2:0] first_bits,
    input  logic       append_crc,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       underrun
);

    tx_state_t   state;
    tx_state_t   state_nxt;

    logic        rdy_en;
    logic [7:0]  shreg;
    logic [3:0]  bit_cnt;
    logic        par_acc;
    logic        last_held;
    logic        first_byte;
    logic [2:0]  first_len;
    logic        crc_en;
    logic [15:0] crc;
    logic [15:0] crc_seed;
    logic [15:0] crc_nxt;
    logic [3:0]  data_len;
    logic        data_end;
    logic        crc_par_slot;
    logic        accept;
    logic        xfer;

    assign data_len     = (first_byte && first_len != 3'd0) ? {1'b0, first_len} : 4'd8;
    assign data_end     = (bit_cnt == data_len - 4'd1);
    assign crc_par_slot = (bit_cnt == 4'd8);
    assign accept       = in_valid && in_ready;
    assign xfer         = out_valid && out_ready;
    assign busy         = (state != IDLE);

    // The first byte of a frame folds into the preset, later bytes into the running value.
    assign crc_seed = (state == IDLE) ? CRC_INIT : crc;

    crc_a_byte u_crc (
        .crc      (crc_seed),
        .data     (in_data),
        .crc_next (crc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rdy_en;
                if (in_valid && rdy_en) begin
                    state_nxt = SOC;
                end
            end
            SOC: begin
                out_valid = 1'b1;
                out_bit   = 1'b1;
                if (out_ready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                out_valid = 1'b1;
                out_bit   = shreg[0];
                if (out_ready && data_end) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                out_valid = 1'b1;
                out_bit   = ~par_acc;
                if (last_held) begin
                    out_last = ~crc_en;
                    if (out_ready) begin
                        state_nxt = crc_en ? CRC_LO : IDLE;
                    end
                end else begin
                    // A missing follow-on byte turns this parity bit into the frame end.
                    in_ready = out_ready;
                    out_last = ~in_valid;
                    if (out_ready) begin
                        state_nxt = in_valid ? DATA : IDLE;
                    end
                end
            end
            CRC_LO, CRC_HI: begin
                out_valid = 1'b1;
                out_bit   = crc_par_slot ? ~par_acc : shreg[0];
                out_last  = (state == CRC_HI) && crc_par_slot;
                if (out_ready && crc_par_slot) begin
                    state_nxt = (state == CRC_LO) ? CRC_HI : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= 8'h00;
            bit_cnt    <= 4'd0;
            par_acc    <= 1'b0;
            last_held  <= 1'b0;
            first_byte <= 1'b0;
            first_len  <= 3'd0;
            crc_en     <= 1'b0;
            crc        <= CRC_INIT;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept) begin
                shreg     <= in_data;
                last_held <= in_last;
                crc       <= crc_nxt;
                par_acc   <= 1'b0;
                bit_cnt   <= 4'd0;
                if (state == IDLE) begin
                    first_byte <= 1'b1;
                    first_len  <= first_bits;
                    crc_en     <= append_crc;
                end else begin
                    first_byte <= 1'b0;
                end
            end else if (xfer) begin
                case (state)
                    DATA: begin
                        shreg   <= {1'b0, shreg[7:1]};
                        par_acc <= par_acc ^ shreg[0];
                        bit_cnt <= data_end ? 4'd0 : bit_cnt + 4'd1;
                    end
                    PARITY: begin
                        if (!last_held) begin
                            underrun <= 1'b1;
                        end else if (crc_en) begin
                            shreg   <= crc[7:0];
                            par_acc <= 1'b0;
                            bit_cnt <= 4'd0;
                        end
                    end
                    CRC_LO, CRC_HI: begin
                        if (crc_par_slot) begin
                            shreg   <= crc[15:8];
                            par_acc <= 1'b0;
                            bit_cnt <= 4'd0;
                        end else begin
                            shreg   <= {1'b0, shreg[7:1]};
                            par_acc <= par_acc ^ shreg[0];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: begin
                        bit_cnt <= bit_cnt;
                    end
                endcase
            end
        end
    end

endmodule
